serial_sub: RTL and testbench

- Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock, LSB first, using a single full-adder cell and a borrow flip-flop.
- Companion to the combinational full-adder cell. Takes operands on a start/done handshake and sits beside the ALU datapath in the lab CPU for the multi-cycle SUB/CMP instructions.
- Intended to trade area for latency.

---
 rtl/serial_sub.sv | 152 +++++++++++++++
 tb/tb_serial_sub.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
`timescale 1ns/1ps
// Bit-serial two's-complement subtractor (diff = a - b), one bit per clock, LSB first.
// Latency: done pulses in the cycle after start edge + WIDTH; busy covers RUN and DONE.
// Backpressure: start is sampled only in IDLE; requests while busy are ignored.
//
// Optional build macro SERIAL_SUB_FLAGS_EN adds zero/neg/ovf result flags.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    // Counter must reach WIDTH-1 without wrapping for any legal WIDTH (1..32).
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sa;        // minuend shift register, bit 0 is the active bit
    logic [WIDTH-1:0] sb;        // subtrahend shift register
    logic [WIDTH-1:0] res;       // partial result, filled from the MSB side
    logic [WIDTH-1:0] res_nxt;
    logic             bw;        // borrow carried between bit positions
    logic             bw_nxt;
    logic             d;         // difference bit of the current position
    logic [CW-1:0]    cnt;       // index of the bit being processed
    logic             last_bit;
    logic             accept;

    // Single full-subtractor cell plus the result shift that follows it.
    always_comb begin
        d        = sa[0] ^ sb[0] ^ bw;
        bw_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
        res_nxt  = res >> 1;
        res_nxt[WIDTH-1] = d;
        last_bit = (cnt == LAST);
        accept   = (state == S_IDLE) && start;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs (busy/done decode straight from state).
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting and result hand-off on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            bw         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            res <= '0;
            bw  <= 1'b0;
            cnt <= '0;
        end else if (state == S_RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= res_nxt;
            bw  <= bw_nxt;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
                // diff/borrow_out only move here, so they stay stable between ops.
                diff       <= res_nxt;
                borrow_out <= bw_nxt;
            end
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    // Operand sign bits are shifted out of sa/sb, so keep copies for overflow.
    logic a_msb;
    logic b_msb;

    // Capture operand signs on accept; publish flags alongside diff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if ((state == S_RUN) && last_bit) begin
            zero <= (res_nxt == '0);
            neg  <= res_nxt[WIDTH-1];
            ovf  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_serial_sub.sv
`timescale 1ns/1ps
// Self-checking bench for serial_sub: WIDTH=8 instance against a timeline model,
// plus a WIDTH=1 instance swept with literal expectations.
// Flag outputs are checked when built with SERIAL_SUB_FLAGS_EN.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         borrow_out;

    logic         s1_start;
    logic [0:0]   s1_a, s1_b;
    logic         s1_busy, s1_done;
    logic [0:0]   s1_diff;
    logic         s1_borrow;

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero, neg, ovf;
    logic s1_zero, s1_neg, s1_ovf;
`endif

    serial_sub #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf)
`endif
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s1_start),
        .a          (s1_a),
        .b          (s1_b),
        .busy       (s1_busy),
        .done       (s1_done),
        .diff       (s1_diff),
        .borrow_out (s1_borrow)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero       (s1_zero),
        .neg        (s1_neg),
        .ovf        (s1_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t = cycles since the accepting edge (0 = idle). The op is busy for
    // cycles 1..W+1, the result appears and done pulses in cycle W+1.
    int           m_t    = 0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic [W-1:0] m_diff = '0;
    logic         m_bo   = 1'b0;
    logic [2:0]   m_flg  = '0;   // {zero, neg, ovf}

    function automatic logic [2:0] flags_of(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] dd;
        dd = x - y;
        return {dd == '0, dd[W-1], (x[W-1] != y[W-1]) && (dd[W-1] != x[W-1])};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 0;
            m_diff <= '0;
            m_bo   <= 1'b0;
            m_flg  <= '0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t <= 1;
                m_a <= a;
                m_b <= b;
            end
        end else if (m_t == W + 1) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == W) begin
                m_diff <= m_a - m_b;
                m_bo   <= (m_a < m_b);
                m_flg  <= flags_of(m_a, m_b);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy",   busy,       (m_t != 0));
            check("cyc_done",   done,       (m_t == W + 1));
            check("cyc_diff",   diff,       m_diff);
            check("cyc_borrow", borrow_out, m_bo);
`ifdef SERIAL_SUB_FLAGS_EN
            check("cyc_flags",  {zero, neg, ovf}, m_flg);
`endif
        end
    end

    // One WIDTH=8 op: literal latency, busy coverage and result checks.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input string nm);
        int n;
        int nbusy;
        bit seen;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~x; b = ~y;           // operands are free to move after capture
        n = 0; nbusy = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
            if (done) seen = 1'b1;
        end
        check({nm, "_latency"}, n, W + 1);
        check({nm, "_busy"}, nbusy, W + 1);
        check({nm, "_diff"}, diff, ed);
        check({nm, "_borrow"}, borrow_out, eb);
    endtask

    logic [0:0] e1_diff [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       e1_bo   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin : main
        int ndone;
        int n;
        logic [1:0] ab;
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",   busy,       0);
        check("rst_done",   done,       0);
        check("rst_diff",   diff,       0);
        check("rst_borrow", borrow_out, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Basic op and the sign/borrow corner cases.
        run_op(8'd100, 8'd37, 8'd63, 1'b0, "t100_37");
        run_op(8'h05, 8'h09, 8'hFC, 1'b1, "t05_09");
`ifdef SERIAL_SUB_FLAGS_EN
        check("t05_09_neg", neg, 1); check("t05_09_zero", zero, 0); check("t05_09_ovf", ovf, 0);
`endif
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, "t80_01");
`ifdef SERIAL_SUB_FLAGS_EN
        check("t80_01_ovf", ovf, 1); check("t80_01_neg", neg, 0);
`endif
        run_op(8'h3C, 8'h3C, 8'h00, 1'b0, "t3c_3c");
`ifdef SERIAL_SUB_FLAGS_EN
        check("t3c_3c_zero", zero, 1);
`endif

        // start held high, operands changing every cycle.
        @(negedge clk);
        a = 8'd10; b = 8'd3; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) check("hold_first_diff", diff, 8'd7);
            end
            a = W'(i * 29 + 7);
            b = W'(i * 13 + 91);
        end
        start = 1'b0;
        check("hold_ops", ndone, 4);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_drain", busy, 0);

        // Reset pulled mid-RUN.
        @(negedge clk);
        a = 8'h5A; b = 8'h13; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   busy,       0);
        check("abort_done",   done,       0);
        check("abort_diff",   diff,       0);
        check("abort_borrow", borrow_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        run_op(8'd200, 8'd55, 8'd145, 1'b0, "t200_55");

        // WIDTH=1 exhaustive sweep.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            @(negedge clk);
            s1_a = ab[1]; s1_b = ab[0]; s1_start = 1'b1;
            @(posedge clk);
            #1 s1_start = 1'b0;
            n = 0;
            while (n < 10) begin
                @(negedge clk);
                n++;
                if (s1_done) break;
            end
            check("w1_latency", n, 2);
            check("w1_diff",    s1_diff,   e1_diff[i]);
            check("w1_borrow",  s1_borrow, e1_bo[i]);
        end

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
